// File: rtl/result_display_seq.sv
// Result display sequencer: captures four result words and shows one at a time
// as hex on a time-multiplexed 4-digit 7-segment display, with manual/auto paging.
//
//  state | meaning
//  ------+---------------------------------------------
//  EMPTY | nothing captured yet, every digit shows dash
//  SHOW  | captured word selected by page is displayed
module result_display_seq #(
    parameter int RES_W     = 16,
    parameter int DIG_DIV   = 2500,
    parameter int AUTO_PAGE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid,
    input  logic [RES_W-1:0] res0,
    input  logic [RES_W-1:0] res1,
    input  logic [RES_W-1:0] res2,
    input  logic [RES_W-1:0] res3,
    input  logic             next,
    output logic             res_ready,
    output logic [6:0]       seg,
    output logic [3:0]       an,
    output logic [1:0]       page,
    output logic             all_shown
);

    localparam int DIV_W = $clog2(DIG_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIG_DIV - 1);
    localparam int TMR_W = (AUTO_PAGE > 1) ? $clog2(AUTO_PAGE) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((AUTO_PAGE > 0) ? AUTO_PAGE - 1 : 0);

    typedef enum logic {EMPTY, SHOW} state_t;

    state_t           state, state_n;
    logic [RES_W-1:0] words   [4];
    logic [RES_W-1:0] words_n [4];
    logic [1:0]       page_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic [1:0]       dig, dig_n;
    logic [TMR_W-1:0] tmr, tmr_n;
    logic             next_q;
    logic             adv, auto_tc, wrap_n;
    logic [15:0]      wide_n;
    logic [3:0]       nib_n;
    logic             blank_n;
    logic [6:0]       seg_n;
    logic [3:0]       an_n;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign res_ready = 1'b1;

    always_comb begin
        state_n = state;
        words_n = words;
        page_n  = page;
        tmr_n   = tmr;
        wrap_n  = 1'b0;
        adv     = next & ~next_q;
        auto_tc = (AUTO_PAGE > 0) && (tmr == TMR_LAST);

        // Capture wins over any advance in the same cycle.
        if (res_valid) begin
            state_n    = SHOW;
            words_n[0] = res0;
            words_n[1] = res1;
            words_n[2] = res2;
            words_n[3] = res3;
            page_n     = 2'd0;
            tmr_n      = '0;
        end else if (state == SHOW) begin
            if (adv || auto_tc) begin
                page_n = page + 2'd1;
                wrap_n = (page == 2'd3);
                tmr_n  = '0;
            end else if (AUTO_PAGE > 0) begin
                tmr_n = tmr + 1'b1;
            end
        end else begin
            tmr_n = '0;
        end

        if (div_cnt == DIV_LAST) begin
            div_n = '0;
            dig_n = dig + 2'd1;
        end else begin
            div_n = div_cnt + 1'b1;
            dig_n = dig;
        end

        // Display is decoded from next-state values so seg and an switch together.
        wide_n  = 16'(words_n[page_n]);
        nib_n   = wide_n[{dig_n, 2'b00} +: 4];
        blank_n = (int'({dig_n, 2'b00}) >= RES_W);
        an_n    = ~(4'b0001 << dig_n);
        if (state_n == EMPTY)
            seg_n = 7'b1000000;
        else if (blank_n)
            seg_n = 7'b0000000;
        else
            seg_n = hex7(nib_n);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= EMPTY;
            for (int i = 0; i < 4; i++) words[i] <= '0;
            page      <= 2'd0;
            div_cnt   <= '0;
            dig       <= 2'd0;
            next_q    <= 1'b0;
            tmr       <= '0;
            seg       <= 7'b1000000;
            an        <= 4'b1110;
            all_shown <= 1'b0;
        end else begin
            state     <= state_n;
            words     <= words_n;
            page      <= page_n;
            div_cnt   <= div_n;
            dig       <= dig_n;
            next_q    <= next;
            tmr       <= tmr_n;
            seg       <= seg_n;
            an        <= an_n;
            all_shown <= wrap_n;
        end
    end

endmodule

// File: doc/result_display_seq.md
Name: result_display_seq

Overview:
Output-side counterpart of the keypad input buffer. It captures the four matrix-multiplier result words when they become valid. It shows one result word at a time as hex digits on a time-multiplexed 4-digit 7-segment display, and pages through the words on a key press or automatically. It sits between the MatrixMultiplier result ports and the board display pins. It replaces the per-result direct segment decode.

Parameters:
RES_W, 16, result word width in bits; multiple of 4, range 4..16
DIG_DIV, 2500, clock cycles each digit stays enabled during scan (>=2)
AUTO_PAGE, 0, cycles per automatic page advance; 0 = manual paging only

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low
res_valid  input  1  results present on res0..res3 this cycle
res0  input  RES_W  result word 0
res1  input  RES_W  result word 1
res2  input  RES_W  result word 2
res3  input  RES_W  result word 3
next  input  1  page-advance request, level, debounced upstream
res_ready  output  1  block can accept a capture
seg  output  7  segment drive, active-high, order {g,f,e,d,c,b,a}
an  output  4  digit enables, active-low, an[0] = rightmost digit
page  output  2  index of the result word currently displayed
all_shown  output  1  one-cycle pulse when paging wraps 3->0

Behaviour:
- Reset (rst==0 at posedge clk): state EMPTY; captured words = 0; page = 0; div_cnt = 0; dig = 0; next_q = 0; page timer = 0.
- Outputs after reset: an = 4'b1110; seg = 7'b1000000 (dash); res_ready = 1; all_shown = 0.
- Reset mid-operation: same values are restored on the next edge; captured data is lost.
- States:
  - EMPTY: every digit shows dash.
  - SHOW: display the captured word indexed by page.
- Capture:
  - Fires when res_valid & res_ready at a clock edge.
  - Latches res0..res3, forces page = 0, clears the page timer, enters SHOW.
  - res_ready is constant 1 in both states; a capture in SHOW overwrites the data and restarts at page 0.
- Paging edge detect: next_q <= next every cycle; adv = next & ~next_q.
  - In EMPTY, adv is ignored.
  - In SHOW: page <= page + 1 mod 4. On the 3->0 wrap, all_shown = 1 for exactly one cycle, the cycle after the advancing edge.
  - A manual advance clears the page timer.
- Auto paging (AUTO_PAGE>0, SHOW only):
  - The page timer counts 0..AUTO_PAGE-1; at the terminal count it produces an advance identical to adv and returns to 0.
  - The timer is held at 0 in EMPTY.
- Simultaneous events:
  - Capture beats adv and the timer: page = 0, no all_shown.
  - adv and timer terminal in the same cycle produce one advance, not two.
- Digit scan: runs continuously in both states.
  - div_cnt counts 0..DIG_DIV-1; on wrap, dig <= dig + 1 mod 4.
  - an = ~(4'b0001 << dig).
- Digit content in SHOW:
  - Digit d shows nibble d (bits 4d+3:4d) of word[page].
  - Digits with 4d >= RES_W are blank (7'b0000000).
- Hex encoding (gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Registering: seg, an, page and all_shown are registered. A capture, page change or digit change is visible on the outputs one clock after the causing edge, and seg/an always change in the same cycle (no ghost digit).
- Width: captured words are RES_W bits, no sign handling; values are displayed raw.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release, DIG_DIV=4 -> an=1110, seg=40, res_ready=1. After 4 cycles an=1101 and seg stays 40; an cycles 1110->1101->1011->0111->1110.
- Capture: res0=16'h12AF, res1..3=16'h0000, pulse res_valid -> page=0. Digits an=1110/1101/1011/0111 show seg 71/77/5B/06.
- Manual paging: res1=16'h00C3, raise next and hold high 10 cycles -> exactly one advance, page=1, digit0=4F, digit1=39. Three more rising edges -> page 2, 3, 0, with all_shown high for exactly one cycle at the wrap.
- Overwrite: at page=2, capture new set with res0=16'h0005 while next rises in the same cycle -> page=0, digit0=6D, no all_shown.
- Auto paging: AUTO_PAGE=8, capture -> page increments every 8 cycles, all_shown once per 32 cycles. A manual edge at timer count 5 advances once and restarts the count.
- Narrow width: RES_W=8, res0=8'h9E -> digit0=79, digit1=6F, digits 2-3 = 00. next in EMPTY before any capture -> page stays 0, seg stays 40.
